fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fq_ring.sv | 71 +++++++
 rtl/fetch_queue.sv | 133 +++++++++++++
 tb/tb_fetch_queue.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// +----------------------------------------------------------------------+
// | fetch_pkg                                                            |
// | Shared types and constants for the instruction fetch queue.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

  localparam int FQ_DATA_WIDTH = 32;
  localparam int FQ_ADDR_WIDTH = 32;

  localparam logic [31:0] FQ_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [FQ_DATA_WIDTH-1:0] instr;
    logic [FQ_ADDR_WIDTH-1:0] pc;
  } fq_entry_t;

  typedef enum logic [0:0] {
    FQ_BOOT = 1'b0,
    FQ_RUN  = 1'b1
  } fq_state_t;

endpackage

`default_nettype wire

// File: rtl/fq_ring.sv
// +----------------------------------------------------------------------+
// | fq_ring                                                              |
// | DEPTH-entry ring buffer with read/write pointers, count and flush.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fq_ring #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// +----------------------------------------------------------------------+
// | fetch_queue                                                          |
// | Instruction fetch queue with slot-reserving requests and redirect.   |
// | Optional same-cycle bypass when empty: FETCH_QUEUE_BYPASS_EN.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                         DATA_WIDTH    = 32,
  parameter int                         ADDRESS_WIDTH = 32,
  parameter int                         DEPTH         = 4,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]      redirect_pc,
  output logic                          imem_req,
  output logic [ADDRESS_WIDTH-1:0]      imem_addr,
  input  logic [DATA_WIDTH-1:0]         imem_rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_instr,
  output logic [ADDRESS_WIDTH-1:0]      out_pc,
  output logic [ADDRESS_WIDTH-1:0]      out_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int             CNT_W   = $clog2(DEPTH+1);
  localparam int             ENTRY_W = DATA_WIDTH + ADDRESS_WIDTH;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

  fq_state_t                state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                     inflight_q, inflight_d;
  logic                     kill_q, kill_d;

  logic                     w_resp;
  logic                     w_bypass;
  logic                     w_fire;
  logic                     w_push;
  logic                     w_pop;
  logic [CNT_W:0]           w_need;
  logic [ENTRY_W-1:0]       w_resp_entry;
  logic [ENTRY_W-1:0]       w_head;
  logic [ENTRY_W-1:0]       ring_rdata;
  logic [CNT_W-1:0]         ring_count;

  assign w_resp       = inflight_q & ~kill_q;
  assign w_resp_entry = {imem_rdata, req_pc_q};

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_resp & (ring_count == '0);
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    // A request is only issued if the arriving response and this one both have a slot.
    w_need       = {1'b0, ring_count} + {{CNT_W{1'b0}}, w_resp} + {{CNT_W{1'b0}}, 1'b1};
    imem_req     = (state_q == FQ_RUN) & ~redirect_valid & (w_need <= DEPTH_C);
    imem_addr    = pc_q;

    w_head       = w_bypass ? w_resp_entry : ring_rdata;
    out_valid    = ((ring_count != '0) | w_bypass) & ~redirect_valid;
    w_fire       = out_valid & out_ready;
    w_pop        = w_fire & ~w_bypass;
    w_push       = w_resp & ~redirect_valid & ~(w_bypass & w_fire);

    out_instr    = out_valid ? w_head[ENTRY_W-1 -: DATA_WIDTH] : DATA_WIDTH'(FQ_NOP);
    out_pc       = w_head[ADDRESS_WIDTH-1:0];
    out_pc_plus4 = out_pc + ADDRESS_WIDTH'(4);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    kill_d     = 1'b0;
    case (state_q)
      FQ_BOOT: state_d = FQ_RUN;
      FQ_RUN:  state_d = FQ_RUN;
      default: state_d = FQ_BOOT;
    endcase
    if (redirect_valid) begin
      pc_d   = redirect_pc;
      kill_d = 1'b1;
    end else if (imem_req) begin
      pc_d     = pc_q + ADDRESS_WIDTH'(4);
      req_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FQ_BOOT;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  fq_ring #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_resp_entry),
    .rdata (ring_rdata),
    .count (ring_count)
  );

  assign count = ring_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model plus directed pins.
`default_nettype none

module tb_fetch_queue;

  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int FIRST = BYP ? 2 : 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [2:0]  count;

  always #5 clk = ~clk;

  fetch_queue #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (32),
    .DEPTH         (DEPTH),
    .RESET_PC      (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .count          (count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc, m_ipc, salt, last_addr;
  bit          m_boot, m_infl;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_pc4, s_instr;
  int          s_count;

  task automatic model_reset();
    mq.delete();
    m_pc      = 32'h0;
    m_ipc     = 32'h0;
    m_boot    = 1'b1;
    m_infl    = 1'b0;
    last_addr = 32'h0;
  endtask

  // One cycle: drive inputs, compare outputs against the model, advance the model.
  task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
    ent_t        h;
    bit          hv, ereq, pop;
    logic [31:0] p4;
    @(negedge clk);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_rdata     = last_addr ^ salt;
    #1;
    ereq = !m_boot && !rv && (mq.size() + int'(m_infl) + 1 <= DEPTH);
    hv = 1'b0;
    h.pc = '0;
    h.instr = '0;
    if (mq.size() > 0) begin
      h  = mq[0];
      hv = 1'b1;
    end else if (BYP && m_infl) begin
      h.pc    = m_ipc;
      h.instr = m_ipc ^ salt;
      hv      = 1'b1;
    end
    if (rv) hv = 1'b0;
    chk("imem_req", {31'b0, imem_req}, {31'b0, ereq});
    if (ereq) chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", {31'b0, out_valid}, {31'b0, hv});
    if (hv) begin
      p4 = h.pc + 32'd4;
      chk("out_pc", out_pc, h.pc);
      chk("out_pc_plus4", out_pc_plus4, p4);
      chk("out_instr", out_instr, h.instr);
    end
    chk("count", {29'b0, count}, mq.size());
    s_req = imem_req; s_valid = out_valid; s_addr = imem_addr;
    s_pc = out_pc; s_pc4 = out_pc_plus4; s_instr = out_instr; s_count = int'(count);
    last_addr = imem_addr;
    if (rv) begin
      mq.delete();
      m_pc   = rpc;
      m_infl = 1'b0;
    end else begin
      pop = hv && rdy;
      if (mq.size() > 0) begin
        if (pop) void'(mq.pop_front());
        if (m_infl) mq.push_back('{m_ipc, m_ipc ^ salt});
      end else if (m_infl && !(BYP && pop)) begin
        mq.push_back('{m_ipc, m_ipc ^ salt});
      end
      m_infl = ereq;
      m_ipc  = m_pc;
      if (ereq) m_pc = m_pc + 32'd4;
    end
    m_boot = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    #1 rst = 1'b1;
    model_reset();
  endtask

  initial begin
    int seen;
    salt = 32'h0;
    model_reset();

    // Streaming from reset with rdata = addr.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 1'b0, 32'h0);
      if (c == 0) chk("boot_no_req", {31'b0, s_req}, 32'd0);
      if (c == 1) chk("req0_addr", s_addr, 32'h0);
      if (c == 2) chk("req1_addr", s_addr, 32'h4);
      if (c == 3) chk("req2_addr", s_addr, 32'h8);
      if (c == FIRST) begin
        chk("first_valid", {31'b0, s_valid}, 32'd1);
        chk("first_pc", s_pc, 32'h0);
        chk("first_instr", s_instr, 32'h0);
      end
      if (c == FIRST + 1) chk("second_pc", s_pc, 32'h4);
    end

    // Decode stalled: queue fills and requests stop.
    do_reset();
    repeat (12) step(1'b0, 1'b0, 32'h0);
    chk("full_count", s_count, 32'd4);
    chk("full_no_req", {31'b0, s_req}, 32'd0);
    chk("full_head_pc", s_pc, 32'h0);

    // Redirect with three stored and one in flight.
    do_reset();
    repeat (5) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h100);
    chk("pre_redir_count", s_count, 32'd3);
    chk("redir_no_valid", {31'b0, s_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0);
    chk("post_redir_count", s_count, 32'd0);
    chk("post_redir_addr", s_addr, 32'h100);
    step(1'b1, 1'b0, 32'h0);
    chk("post_redir_addr2", s_addr, 32'h104);
    seen = 0;
    for (int c = 0; c < 6 && seen == 0; c++) begin
      step(1'b1, 1'b0, 32'h0);
      if (s_valid) begin
        seen = 1;
        chk("redir_first_pc", s_pc, 32'h100);
      end
    end
    chk("redir_seen", seen, 32'd1);

    // Redirect to the top of the address space: PC wraps.
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    seen = 0;
    for (int c = 0; c < 8 && seen < 2; c++) begin
      step(1'b1, 1'b0, 32'h0);
      if (s_valid) begin
        if (seen == 0) begin
          chk("wrap_pc0", s_pc, 32'hFFFF_FFFC);
          chk("wrap_pc0_plus4", s_pc4, 32'h0);
        end else begin
          chk("wrap_pc1", s_pc, 32'h0);
        end
        seen++;
      end
    end
    chk("wrap_seen", seen, 32'd2);

    // Redirect while a pop would otherwise happen.
    step(1'b1, 1'b0, 32'h0);
    chk("pre_pop_valid", {31'b0, s_valid}, 32'd1);
    step(1'b1, 1'b1, 32'h200);
    chk("redir_pop_valid", {31'b0, s_valid}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("redir_pop_count", s_count, 32'd0);

    // Asynchronous reset between edges with two stored.
    do_reset();
    repeat (5) step(1'b0, 1'b0, 32'h0);
    chk("pre_async_count", s_count, 32'd2);
    #1 rst = 1'b0;
    #1;
    chk("async_count", {29'b0, count}, 32'd0);
    chk("async_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_imem_req", {31'b0, imem_req}, 32'd0);
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("restart_addr", s_addr, 32'h0);
    chk("restart_req", {31'b0, s_req}, 32'd1);

    // Randomized traffic against the model.
    salt = 32'h5A5A_0000;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit          rdy, rv;
      logic [31:0] rpc;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step(rdy, rv, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
